// File: rtl/avrisc621_mc_pkg.sv
// Constants and FSM encoding shared by the multicore cluster's master, slave and return-path logic.
package avrisc621_mc_pkg;

  localparam int MC_NUM_SLAVES = 3;
  localparam int MC_DATA_W     = 8;
  localparam int MC_ID_W       = 2;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SACK = 3'd1,
    SREL = 3'd2,
    MREQ = 3'd3,
    MREL = 3'd4
  } mc_state_e;

endpackage

// File: rtl/slave_result_arbiter_rr_arbiter_comb.sv
// Round-robin request picker: the first requester above rr_last (with wrap) wins.
module rr_arbiter_comb
  import avrisc621_mc_pkg::*;
#(
  parameter int N    = MC_NUM_SLAVES,
  parameter int ID_W = MC_ID_W
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] rr_last,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] grant_idx,
  output logic            any_req
);

  logic [ID_W-1:0] cand;

  // Scanned farthest-first so the nearest requester after rr_last overwrites the rest.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    cand      = '0;
    any_req   = |req;
    for (int off = N; off >= 1; off--) begin
      cand = ID_W'((int'(rr_last) + off) % N);
      if (req[cand]) begin
        grant       = '0;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/slave_result_arbiter.sv
// Slave-to-master result return path: round-robin capture from the slaves, then a
// req/ack presentation of the captured result and its slave ID to the master.
//
//   state | meaning
//   IDLE  | waiting for any slave request; arbitrates and captures on the edge
//   SACK  | S_ack held to the winner until it drops its request
//   SREL  | one-cycle gap; raises M_req and advances the rotation pointer
//   MREQ  | M_req held with stable data/id until the master acknowledges
//   MREL  | waiting for the master to drop M_ack; counts the transfer
module slave_result_arbiter
  import avrisc621_mc_pkg::*;
#(
  parameter int NUM_SLAVES = MC_NUM_SLAVES,
  parameter int DATA_W     = MC_DATA_W,
  parameter int ID_W       = MC_ID_W
) (
  input  logic                       Clock_pin,
  input  logic                       Reset_pin,
  input  logic [NUM_SLAVES-1:0]      S_req,
  input  logic [NUM_SLAVES*DATA_W-1:0] S_data,
  output logic [NUM_SLAVES-1:0]      S_ack,
  output logic                       M_req,
  output logic [DATA_W-1:0]          M_data,
  output logic [ID_W-1:0]            M_id,
  input  logic                       M_ack,
  output logic                       Busy,
  output logic [7:0]                 Xfer_count
);

  mc_state_e             state;
  logic [ID_W-1:0]       rr_last;
  logic [NUM_SLAVES-1:0] grant;
  logic [ID_W-1:0]       grant_idx;
  logic                  any_req;
  logic [DATA_W-1:0]     lane_data [NUM_SLAVES];

  for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_lane
    assign lane_data[g] = S_data[g*DATA_W +: DATA_W];
  end

  rr_arbiter_comb #(
    .N    (NUM_SLAVES),
    .ID_W (ID_W)
  ) u_rr (
    .req       (S_req),
    .rr_last   (rr_last),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_req   (any_req)
  );

  // M_id doubles as the winner register for the whole transfer.
  always_ff @(posedge Clock_pin or posedge Reset_pin) begin
    if (Reset_pin) begin
      state      <= IDLE;
      S_ack      <= '0;
      M_req      <= 1'b0;
      M_data     <= '0;
      M_id       <= '0;
      Busy       <= 1'b0;
      Xfer_count <= '0;
      rr_last    <= ID_W'(NUM_SLAVES - 1);
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            M_data <= lane_data[grant_idx];
            M_id   <= grant_idx;
            S_ack  <= grant;
            Busy   <= 1'b1;
            state  <= SACK;
          end
        end
        SACK: begin
          if (!S_req[M_id]) begin
            S_ack <= '0;
            state <= SREL;
          end
        end
        SREL: begin
          M_req   <= 1'b1;
          rr_last <= M_id;
          state   <= MREQ;
        end
        MREQ: begin
          if (M_ack) begin
            M_req <= 1'b0;
            state <= MREL;
          end
        end
        MREL: begin
          if (!M_ack) begin
            Xfer_count <= Xfer_count + 8'd1;
            Busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          S_ack <= '0;
          M_req <= 1'b0;
          Busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_slave_result_arbiter.sv
// Bench for slave_result_arbiter: transaction-level model plus directed scenarios.
module tb_slave_result_arbiter;

  localparam int N  = 3;
  localparam int DW = 8;
  localparam int IW = 2;

  logic            Clock_pin = 1'b0;
  logic            Reset_pin = 1'b0;
  logic [N-1:0]    S_req = '0;
  logic [N*DW-1:0] S_data = '0;
  logic [N-1:0]    S_ack;
  logic            M_req;
  logic [DW-1:0]   M_data;
  logic [IW-1:0]   M_id;
  logic            M_ack = 1'b0;
  logic            Busy;
  logic [7:0]      Xfer_count;

  int checks = 0;
  int errors = 0;
  bit armed = 0;

  int req_left [N];
  int stall = 0;
  int m_wait = 0;

  logic [IW-1:0] log_id [$];
  logic [DW-1:0] log_data [$];

  // Model: current transaction phase (0 free, 1 slave handshake, 2 gap, 3 master handshake, 4 master release)
  int            md_phase = 0;
  int            md_win = 0;
  int            md_last = N - 1;
  int            md_cnt = 0;
  logic [DW-1:0] md_data = '0;

  always #5 Clock_pin = ~Clock_pin;

  slave_result_arbiter #(.NUM_SLAVES(N), .DATA_W(DW), .ID_W(IW)) dut (
    .Clock_pin  (Clock_pin),
    .Reset_pin  (Reset_pin),
    .S_req      (S_req),
    .S_data     (S_data),
    .S_ack      (S_ack),
    .M_req      (M_req),
    .M_data     (M_data),
    .M_id       (M_id),
    .M_ack      (M_ack),
    .Busy       (Busy),
    .Xfer_count (Xfer_count)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Nearest requester after 'last' in circular distance.
  function automatic int pick(input logic [N-1:0] r, input int last);
    int best = -1;
    int bestd = N + 1;
    for (int i = 0; i < N; i++) begin
      if (r[i]) begin
        int d;
        d = (i - last - 1 + 2 * N) % N;
        if (d < bestd) begin
          bestd = d;
          best = i;
        end
      end
    end
    return best;
  endfunction

  initial begin
    forever begin
      @(posedge Clock_pin or posedge Reset_pin);
      if (Reset_pin) begin
        md_phase = 0; md_last = N - 1; md_cnt = 0; md_win = 0; md_data = '0;
      end else begin
        case (md_phase)
          0: if (S_req != '0) begin
               md_win = pick(S_req, md_last);
               md_data = S_data[md_win*DW +: DW];
               md_phase = 1;
             end
          1: if (!S_req[md_win]) md_phase = 2;
          2: begin md_last = md_win; md_phase = 3; end
          3: if (M_ack) md_phase = 4;
          4: if (!M_ack) begin md_cnt = (md_cnt + 1) % 256; md_phase = 0; end
          default: md_phase = 0;
        endcase
      end
    end
  end

  // Per-cycle comparison against the model, plus a log of each presented result.
  initial begin
    logic prev_mreq;
    logic [N-1:0] exp_ack;
    prev_mreq = 1'b0;
    forever begin
      @(negedge Clock_pin);
      if (Reset_pin) prev_mreq = 1'b0;
      else if (armed) begin
        exp_ack = (md_phase == 1) ? N'(1 << md_win) : '0;
        chk("s_ack", S_ack, exp_ack);
        chk("m_req", M_req, md_phase == 3);
        chk("busy", Busy, md_phase != 0);
        chk("xfer_count", Xfer_count, md_cnt);
        if (md_phase == 3) begin
          chk("m_data", M_data, md_data);
          chk("m_id", M_id, md_win);
        end
        if (M_req && !prev_mreq) begin
          log_id.push_back(M_id);
          log_data.push_back(M_data);
        end
        prev_mreq = M_req;
      end
    end
  end

  // Slave and master responders, all reacting on the falling edge.
  initial begin
    forever begin
      @(negedge Clock_pin);
      for (int i = 0; i < N; i++) begin
        if (S_ack[i] && S_req[i]) begin
          S_req[i] = 1'b0;
          if (req_left[i] > 0) req_left[i]--;
        end else if (!S_ack[i] && !S_req[i] && req_left[i] > 0) begin
          S_req[i] = 1'b1;
        end
      end
      if (!Reset_pin) begin
        if (M_req && !M_ack) begin
          if (m_wait >= stall) M_ack = 1'b1;
          else m_wait++;
        end else if (!M_req && M_ack) begin
          M_ack = 1'b0;
          m_wait = 0;
        end
      end
    end
  end

  task automatic do_reset(input int l0, input int l1, input int l2);
    Reset_pin = 1'b1;
    S_req = '0; M_ack = 1'b0; m_wait = 0; stall = 0;
    req_left[0] = l0; req_left[1] = l1; req_left[2] = l2;
    repeat (2) @(negedge Clock_pin);
    Reset_pin = 1'b0;
    armed = 1;
  endtask

  initial begin
    logic [DW-1:0] hold_d;
    logic [IW-1:0] hold_i;
    int prev;
    bit wrapped;
    int c;

    // Reset state
    #1;
    do_reset(0, 0, 0);
    #1;
    chk("rst_s_ack", S_ack, 0);
    chk("rst_m_req", M_req, 0);
    chk("rst_m_data", M_data, 0);
    chk("rst_m_id", M_id, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_xfer", Xfer_count, 0);

    // 1: single request from slave 1
    S_data = 24'h00_A5_00;
    req_left[1] = 1;
    @(negedge Clock_pin); #1;
    chk("t1_ack_not_early", S_ack, 3'b000);
    @(negedge Clock_pin); #1;
    chk("t1_ack_next_cycle", S_ack, 3'b010);
    for (c = 0; c < 50 && !M_req; c++) @(negedge Clock_pin);
    chk("t1_mreq_seen", M_req, 1);
    chk("t1_m_data", M_data, 8'hA5);
    chk("t1_m_id", M_id, 1);
    for (c = 0; c < 50 && Xfer_count != 8'd1; c++) @(negedge Clock_pin);
    chk("t1_xfer", Xfer_count, 1);
    chk("t1_busy", Busy, 0);

    // 2: all slaves requesting continuously
    S_data = 24'h33_22_11;
    log_id.delete(); log_data.delete();
    do_reset(1000, 1000, 1000);
    for (c = 0; c < 200 && log_id.size() < 4; c++) @(negedge Clock_pin);
    chk("t2_four_grants", log_id.size() >= 4, 1);
    for (int k = 0; k < 4; k++) begin
      chk("t2_id_seq", log_id[k], k % 3);
      chk("t2_data_seq", log_data[k], (k % 3 + 1) * 8'h11);
    end

    // 3: data changes after grant are ignored
    S_data = 24'h00_00_3C;
    do_reset(1, 0, 0);
    stall = 3;
    for (c = 0; c < 50 && !S_ack[0]; c++) @(negedge Clock_pin);
    chk("t3_ack0", S_ack, 3'b001);
    @(negedge Clock_pin);
    S_data = 24'h00_00_FF;
    for (c = 0; c < 50 && !M_req; c++) @(negedge Clock_pin);
    chk("t3_mreq_seen", M_req, 1);
    for (c = 0; c < 20 && M_req; c++) begin
      chk("t3_m_data_stable", M_data, 8'h3C);
      @(negedge Clock_pin);
    end

    // 4: master stall with slave 2 waiting
    S_data = 24'hC2_00_90;
    do_reset(1, 0, 0);
    stall = 10;
    for (c = 0; c < 50 && !M_req; c++) @(negedge Clock_pin);
    chk("t4_mreq_seen", M_req, 1);
    req_left[2] = 1;
    hold_d = M_data;
    hold_i = M_id;
    chk("t4_first_data", hold_d, 8'h90);
    for (int k = 0; k < 10; k++) begin
      chk("t4_mreq_held", M_req, 1);
      chk("t4_data_held", M_data, hold_d);
      chk("t4_id_held", M_id, hold_i);
      chk("t4_sack2_low", S_ack[2], 0);
      @(negedge Clock_pin);
    end
    for (c = 0; c < 50 && !S_ack[2]; c++) @(negedge Clock_pin);
    chk("t4_sack2_after", S_ack, 3'b100);
    chk("t4_count_at_grant2", Xfer_count, 1);
    for (c = 0; c < 50 && Busy; c++) @(negedge Clock_pin);

    // 5: reset during MREQ
    S_data = 24'h33_22_11;
    do_reset(1000, 1000, 1000);
    stall = 50;
    for (c = 0; c < 100 && !(M_req && M_id == 2'd1); c++) @(negedge Clock_pin);
    chk("t5_in_mreq_id1", M_req && M_id == 2'd1, 1);
    chk("t5_count_before", Xfer_count, 1);
    Reset_pin = 1'b1;
    #1;
    chk("t5_async_m_req", M_req, 0);
    chk("t5_async_s_ack", S_ack, 0);
    chk("t5_async_xfer", Xfer_count, 0);
    chk("t5_async_busy", Busy, 0);
    M_ack = 1'b0; m_wait = 0; stall = 0;
    log_id.delete(); log_data.delete();
    repeat (2) @(negedge Clock_pin);
    Reset_pin = 1'b0;
    for (c = 0; c < 50 && log_id.size() < 1; c++) @(negedge Clock_pin);
    chk("t5_grant_after_reset", log_id.size() >= 1, 1);
    chk("t5_first_id", log_id[0], 0);
    chk("t5_first_data", log_data[0], 8'h11);

    // 6: counter wrap over 256 transfers
    do_reset(0, 100000, 0);
    prev = 0;
    wrapped = 0;
    for (c = 0; c < 3000 && !wrapped; c++) begin
      @(negedge Clock_pin);
      if (int'(Xfer_count) != prev) begin
        chk("t6_xfer_step", Xfer_count, (prev + 1) % 256);
        if (prev == 255 && Xfer_count == 8'd0) wrapped = 1;
        prev = int'(Xfer_count);
      end
    end
    chk("t6_wrap_seen", wrapped, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/slave_result_arbiter.md
Name: slave_result_arbiter

Overview:
- Return-path collector for the multicore cluster. Carries results from the slave cores back to the master core.
- Each slave raises a request and holds an 8-bit result on its lane. A round-robin arbiter picks one slave, captures its data and acknowledges it with a 4-phase handshake.
- The captured result and the slave's ID are then presented to the master with a second 4-phase req/ack handshake.
- Replaces the free-running, ID-selected output mux on the master side. Together they form the slave→master direction of the same broadcast protocol.

Parameters:
- NUM_SLAVES, 3, number of slave cores (2..4).
- DATA_W, 8, result width per slave.
- ID_W, 2, slave ID width; must satisfy 2**ID_W >= NUM_SLAVES.

Ports:
- Clock_pin  in  1  single system clock; all logic on the rising edge.
- Reset_pin  in  1  asynchronous, active-high reset.
- S_req  in  NUM_SLAVES  per-slave result request; level, 4-phase.
- S_data  in  NUM_SLAVES*DATA_W  packed slave results; slave i uses bits [i*DATA_W +: DATA_W]; stable while S_req[i]=1.
- S_ack  out  NUM_SLAVES  per-slave acknowledge; one-hot or zero.
- M_req  out  1  result-valid request to master.
- M_data  out  DATA_W  captured result; stable while M_req=1.
- M_id  out  ID_W  index of the slave that produced M_data.
- M_ack  in  1  master acknowledge; level, 4-phase.
- Busy  out  1  high in every state except IDLE.
- Xfer_count  out  8  completed transfers; wraps 255→0.

Behaviour:
- Reset state, asynchronous:
  - state=IDLE.
  - S_ack=0, M_req=0, M_data=0, M_id=0, Busy=0, Xfer_count=0.
  - rr_last=NUM_SLAVES-1, so slave 0 has top priority after reset.
- FSM states: IDLE, SACK, SREL, MREQ, MREL. All outputs are registered.
- IDLE:
  - If any S_req bit is high at the edge, the winner is the first requester found starting from rr_last+1 mod NUM_SLAVES and scanning upward with wrap.
  - At that edge: M_data←S_data[winner], M_id←winner, S_ack[winner]←1, →SACK.
  - S_ack rises one cycle after S_req is sampled.
- SACK: hold S_ack[winner]=1 until S_req[winner]=0 is sampled. At that edge: S_ack←0, →SREL.
- SREL: one-cycle gap. M_req←1, rr_last←winner, →MREQ.
- MREQ:
  - Hold M_req=1, M_data and M_id constant until M_ack=1 is sampled.
  - At that edge: M_req←0, →MREL.
  - M_req is high for at least one full cycle, even if M_ack is already high on entry.
- MREL:
  - Wait for M_ack=0.
  - At that edge: Xfer_count←Xfer_count+1 (mod 256), →IDLE.
  - The next arbitration can occur in the following cycle.
- Minimum transfer: 5 cycles from the S_req sample to return to IDLE, with zero-wait partners.
- Requests arriving while Busy are not lost. They stay pending because S_req is a level and are arbitrated on the next IDLE.
- Simultaneous requests:
  - Exactly one winner per transfer.
  - Strict rotation: no slave is granted twice while another requester keeps waiting.
- S_req dropped in IDLE before it is sampled: no effect.
- Data is latched at grant. S_data changes after S_ack rises are ignored.
- S_req bits of non-winners during SACK..MREL: ignored.
- Reset asserted mid-transfer:
  - Immediate return to the reset state. The captured result is discarded and Xfer_count is cleared.
  - Slaves must restart their handshake.
- M_data and M_id hold their last value in IDLE; they are only meaningful while M_req=1.

Decomposition:
- Shared package avrisc621_mc_pkg:
  - FSM state encoding: IDLE=0, SACK=1, SREL=2, MREQ=3, MREL=4, 3 bits.
  - Constants MC_NUM_SLAVES=3, MC_DATA_W=8, MC_ID_W=2, shared with the master, slave and top-level wrapper.
- One sub-module, rr_arbiter_comb:
  - Purely combinational.
  - Inputs: request vector, rr_last. Outputs: one-hot grant, binary index, any_req.
  - Keeps the priority rotation separately testable.
- The FSM, capture registers and counter stay in slave_result_arbiter.

Test Plan:
1. Single request. Reset, then S_req=3'b010 with slave1 data=0xA5. Expected:
   - S_ack=3'b010 one cycle later.
   - After slave drops S_req: M_req=1, M_data=0xA5, M_id=1.
   - After the master handshake: Xfer_count=1, Busy=0.
2. Simultaneous requests. All three S_req high from reset, data 0x11/0x22/0x33, all slaves re-requesting continuously. Expected:
   - M_id sequence 0,1,2,0.
   - M_data sequence 0x11,0x22,0x33,0x11.
3. Data stability. Change slave0 data 0x3C→0xFF one cycle after S_ack[0] rises. Expected: M_data=0x3C throughout MREQ.
4. Master stall. Hold M_ack=0 for 10 cycles in MREQ while slave2 requests. Expected:
   - M_req stays 1; M_data and M_id are constant.
   - S_ack[2] stays 0 until after MREL→IDLE.
5. Reset mid-transfer. Assert Reset_pin during MREQ. Expected:
   - M_req=0, S_ack=0, Xfer_count=0 with no clock edge.
   - First grant after release goes to slave 0 when all slaves are requesting.
6. Counter wrap. Run 256 transfers. Expected: Xfer_count goes 255→0; no handshake glitches.
